data_mem_responder: RTL and testbench

- Responder end of the core's data-memory load/store path: accepts one word read or write request per handshake and returns a one-cycle acknowledge.
- Holds the data array and inserts a programmable number of wait states.
- Sits between the processor datapath (request initiator) and nothing further: it is the memory endpoint.
- Single clock domain on CLK.

---
 rtl/data_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// -----------------------------------------------------------------------------
// Memory endpoint of the core's data load/store path. Accepts one word read or
// write per handshake while idle, waits a programmable number of cycles, then
// commits the access and returns a one-cycle acknowledge.
//
// Parameters:
//   ADDR_W      word-address width, array depth is 2**ADDR_W 32-bit words
//   WAIT_CYCLES wait states between acceptance and commit (0..15)
//
// Ports:
//   CLK    system clock, all state changes on the rising edge
//   RST    synchronous reset, active-low
//   req    request valid, only looked at while idle
//   we     1 = write, 0 = read, sampled with req
//   addr   byte address, word index is addr[ADDR_W+1:2]
//   wdata  write data, sampled with req
//   rdata  registered read data, holds the last read value
//   ack    one-cycle completion pulse
//   busy   high whenever the responder is not idle
//   err    misalign error, valid with ack
//
// Optional feature (macro DATA_MEM_MISALIGN_TRAP_EN):
//   When defined, a request with addr[1:0] != 0 completes with err=1 and
//   touches neither the array nor rdata. When undefined, err is tied low and
//   the low address bits are ignored.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateType;

    stateType           state;
    logic [3:0]         waitCount;
    logic [31:0]        memArray [2**ADDR_W];

    logic               weLat;
    logic [ADDR_W-1:0]  idxLat;
    logic [31:0]        wdataLat;
    logic               badLat;

    logic [ADDR_W-1:0]  reqIdx;
    logic               reqBad;

    logic               commitEn;
    logic               commitWe;
    logic               commitBad;
    logic [ADDR_W-1:0]  commitIdx;
    logic [31:0]        commitData;
    logic               memWriteEn;
    logic               readEn;

    // Address bits above the array and (without the trap) the byte offset
    // intentionally play no part; they are folded here so they stay visibly
    // accounted for.
    logic               unusedAddrBits;
    assign unusedAddrBits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign reqIdx = addr[ADDR_W+1:2];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign reqBad = (addr[1:0] != 2'b00);
`else
    assign reqBad = 1'b0;
    assign badLat = 1'b0;
    assign err    = 1'b0;
`endif

    // Work out whether this edge is the commit edge and which operands apply.
    // With zero wait states the commit happens on the accepting edge itself,
    // so the live request inputs are used instead of the latched copies.
    always_comb begin
        commitEn   = 1'b0;
        commitWe   = weLat;
        commitBad  = badLat;
        commitIdx  = idxLat;
        commitData = wdataLat;
        if (state == IDLE) begin
            commitWe   = we;
            commitBad  = reqBad;
            commitIdx  = reqIdx;
            commitData = wdata;
            if (req && (WAIT_CYCLES == 0)) begin
                commitEn = 1'b1;
            end
        end else if ((state == WAIT) && (waitCount == 4'd1)) begin
            commitEn = 1'b1;
        end
    end

    assign memWriteEn = commitEn && commitWe && !commitBad;
    assign readEn     = commitEn && !commitWe && !commitBad;

    // The storage array has no reset, but a write whose commit edge lands on
    // a reset edge must be dropped, hence the RST qualifier.
    always_ff @(posedge CLK) begin
        if (RST && memWriteEn) begin
            memArray[commitIdx] <= commitData;
        end
    end

    // Main control FSM. ack, busy and err are registered so they line up with
    // the state they describe: busy mirrors "not IDLE", ack and err are only
    // set on the edge that enters RESP.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            waitCount <= 4'd0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            rdata     <= 32'h0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
            err       <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        weLat     <= we;
                        idxLat    <= reqIdx;
                        wdataLat  <= wdata;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
                        badLat    <= reqBad;
`endif
                        waitCount <= 4'(WAIT_CYCLES);
                        busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                            ack   <= 1'b1;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
                            err   <= reqBad;
`endif
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    waitCount <= waitCount - 4'd1;
                    if (waitCount == 4'd1) begin
                        state <= RESP;
                        ack   <= 1'b1;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
                        err   <= badLat;
`endif
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (readEn) begin
                rdata <= memArray[commitIdx];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// -----------------------------------------------------------------------------
// Scoreboard bench for data_mem_responder (ADDR_W=10, WAIT_CYCLES=2).
// The stimulus side issues requests and, at the accepting edge, pushes the
// expected response computed from a word-array reference model. A separate
// monitor samples the DUT on the falling edge and pops/compares whenever an
// acknowledge is due. Honours DATA_MEM_MISALIGN_TRAP_EN if defined.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int AW = 10;
    localparam int WC = 2;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        CLK   = 1'b0;
    logic        RST   = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    data_mem_responder #(
        .ADDR_W      (AW),
        .WAIT_CYCLES (WC)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .busy  (busy),
        .err   (err)
    );

    always #5 CLK = ~CLK;

    // Rising-edge count; a request accepted at edge N acks in the cycle
    // after edge N+WC.
    int cycle = 0;
    always @(posedge CLK) cycle <= cycle + 1;

    typedef struct {
        bit          isWrite;
        bit          expErr;
        logic [31:0] expRdata;
        int          acc;
    } expType;

    expType      sbQueue[$];
    expType      monEntry;
    logic [31:0] refMem [int];
    logic [31:0] refRdata   = 32'h0;
    logic [31:0] heldRdata  = 32'h0;
    int          activeAcc  = -100;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // Word index as plain arithmetic: wrap the byte address to the array's
    // byte span, then divide by the word size.
    function automatic int refIdx(input logic [31:0] a);
        return int'((a % (32'd1 << (AW + 2))) / 32'd4);
    endfunction

    // Issue one request (called at posedge+2). Waits for idle, drives the
    // request, and at the accepting edge updates the reference model and
    // queues the expected response. With hold=1 req stays high and the other
    // inputs are scrambled while the DUT is busy.
    task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d, input bit hold);
        int     guard = 0;
        int     idx;
        bit     bad;
        expType e;
        while (busy !== 1'b0 && guard < 50) begin
            @(posedge CLK); #2;
            guard++;
        end
        if (guard >= 50) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL idleWait: busy stuck at %b, required 0", busy);
        end
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge CLK); #2;
        activeAcc = cycle;
        idx = refIdx(a);
        bad = TRAP && ((a % 32'd4) != 32'd0);
        if (!bad) begin
            if (w) begin
                refMem[idx] = d;
            end else if (refMem.exists(idx)) begin
                refRdata = refMem[idx];
            end else begin
                refRdata = 32'hx;
            end
        end
        e.isWrite  = w;
        e.expErr   = bad;
        e.expRdata = refRdata;
        e.acc      = cycle;
        sbQueue.push_back(e);
        if (!hold) begin
            req = 1'b0;
        end
        we    = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    // Monitor: checks busy every falling edge, and either the due response or
    // the quiet-cycle invariants (no ack, no err, rdata held).
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                heldRdata = 32'h0;
            end else begin
                while (sbQueue.size() > 0 && sbQueue[0].acc + WC < cycle) begin
                    monEntry = sbQueue.pop_front();
                    checkOutput("ackMissing", 32'(1'b0), 32'(1'b1));
                end
                checkOutput("busy", 32'(busy), 32'((cycle >= activeAcc) && (cycle <= activeAcc + WC)));
                if (sbQueue.size() > 0 && sbQueue[0].acc + WC == cycle) begin
                    monEntry = sbQueue.pop_front();
                    checkOutput("ack", 32'(ack), 32'(1'b1));
                    checkOutput("err", 32'(err), 32'(monEntry.expErr));
                    checkOutput(monEntry.isWrite ? "rdataAfterWrite" : "rdataRead", rdata, monEntry.expRdata);
                    heldRdata = monEntry.expRdata;
                end else begin
                    checkOutput("ackQuiet", 32'(ack), 32'(1'b0));
                    checkOutput("errQuiet", 32'(err), 32'(1'b0));
                    checkOutput("rdataHold", rdata, heldRdata);
                end
            end
        end
    end

    // Stimulus sequence: directed scenarios followed by random traffic.
    initial begin
        int          prevAcc;
        logic [31:0] a;

        repeat (3) @(posedge CLK);
        #2;
        checkOutput("resetAck", 32'(ack), 32'(1'b0));
        checkOutput("resetBusy", 32'(busy), 32'(1'b0));
        checkOutput("resetErr", 32'(err), 32'(1'b0));
        checkOutput("resetRdata", rdata, 32'h0);
        RST = 1'b1;
        @(posedge CLK); #2;

        // Known contents for the word pool used by the rest of the run.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'(i * 4), $urandom, 1'b0);
        end

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);

        // Aliasing: 0x1000 wraps onto word 0.
        applyStimulus(1'b1, 32'h1000, 32'h12345678, 1'b0);
        applyStimulus(1'b0, 32'h0000, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h0004, 32'hA5A5A5A5, 1'b0);
        applyStimulus(1'b0, 32'h0004, 32'h0, 1'b0);

        // Back-to-back reads with req held high.
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b1);
        prevAcc = activeAcc;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("burstSpacing1", 32'(activeAcc - prevAcc), 32'(WC + 2));
        prevAcc = activeAcc;
        applyStimulus(1'b0, 32'h4, 32'h0, 1'b0);
        checkOutput("burstSpacing2", 32'(activeAcc - prevAcc), 32'(WC + 2));

        // Reset landing on the commit edge of a write abandons it.
        repeat (WC + 2) begin
            @(posedge CLK); #2;
        end
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'hCAFEF00D;
        @(posedge CLK); #2;
        activeAcc = cycle;
        req = 1'b0;
        @(posedge CLK); #2;
        RST = 1'b0;
        @(posedge CLK); #2;
        activeAcc = -100;
        refRdata  = 32'h0;
        checkOutput("midResetAck", 32'(ack), 32'(1'b0));
        checkOutput("midResetBusy", 32'(busy), 32'(1'b0));
        checkOutput("midResetErr", 32'(err), 32'(1'b0));
        checkOutput("midResetRdata", rdata, 32'h0);
        RST = 1'b1;
        @(posedge CLK); #2;
        applyStimulus(1'b0, 32'h20, 32'h0, 1'b0);

        // Misaligned write: trapped with the feature, plain word write without.
        applyStimulus(1'b1, 32'h22, 32'h0BADF00D, 1'b0);
        applyStimulus(1'b0, 32'h20, 32'h0, 1'b0);

        // Random traffic over the pool with random alias bits and offsets.
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            a[AW+1:2] = AW'($urandom_range(0, 15));
            applyStimulus(1'($urandom), a, $urandom, 1'($urandom));
        end
        req = 1'b0;

        repeat (WC + 6) begin
            @(posedge CLK); #2;
        end
        checkOutput("drained", 32'(sbQueue.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
